// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU execution core:
// opcodes, micro-state codes, ALU modes and register codes.
package cpu_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_CALL = 8'h01;
  localparam logic [7:0] OP_RET  = 8'h02;
  localparam logic [7:0] OP_OUT  = 8'h03;
  localparam logic [7:0] OP_HLT  = 8'h04;
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_JZ   = 8'h11;
  localparam logic [7:0] OP_JNZ  = 8'h12;

  // Top-two-bit instruction groups; LDI is group 00 with sub-field 011.
  localparam logic [1:0] GRP_MISC = 2'b00;
  localparam logic [1:0] GRP_ALU  = 2'b01;
  localparam logic [1:0] GRP_MOV  = 2'b10;
  localparam logic [2:0] SUB_LDI  = 3'b011;
  localparam logic [2:0] REG_MEM  = 3'b111;

  typedef enum logic [7:0] {
    S_NEXT       = 8'h00,
    S_FETCH_PC   = 8'h01,
    S_FETCH_INST = 8'h02,
    S_HALT       = 8'h03,
    S_JUMP       = 8'h04,
    S_OUT_A      = 8'h05,
    S_ALU_OP     = 8'h06,
    S_MOV_FETCH  = 8'h07,
    S_MOV_LOAD   = 8'h08,
    S_MOV_STORE  = 8'h09,
    S_LDI        = 8'h0A,
    S_FETCH_SP   = 8'h0B,
    S_PC_STORE   = 8'h0C,
    S_TMP_STORE  = 8'h0D,
    S_TMP_JUMP   = 8'h0E,
    S_INC_SP     = 8'h0F,
    S_RET        = 8'h10
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_INC = 3'b010,
    ALU_DEC = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_NOT = 3'b111
  } alu_mode_t;

endpackage

// File: rtl/cpu_exec_core_counter.sv
// Loadable up/down counter used for both PC and SP; load wins over enable,
// so reset values are forced through the load path.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic             load,
  input  logic             down,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (load) begin
      q <= d;
    end else if (en) begin
      q <= down ? q - 1'b1 : q + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_exec_core.sv
// Execution core: micro-cycle sequencer, PC/SP counters and the 8-bit ALU.
// The micro-state is decoded combinationally from the cycle count and opcode.
module cpu_exec_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] opcode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] rega,
  input  logic [WIDTH-1:0] regb,
  output logic [7:0]       state,
  output logic [3:0]       cycle,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] alu_out,
  output logic             eq_zero,
  output logic             halted
);

  state_t     cur_state;
  logic [3:0] cycle_reg;
  logic       halted_reg;
  logic [3:0] idx;
  logic       is_alu, is_mov, is_ldi, is_jump_op, mov_memory, jump_taken;

  assign is_alu     = (opcode[7:6] == GRP_ALU);
  assign is_mov     = (opcode[7:6] == GRP_MOV);
  assign is_ldi     = (opcode[7:6] == GRP_MISC) && (opcode[5:3] == SUB_LDI);
  assign is_jump_op = (opcode == OP_JMP) || (opcode == OP_JZ) || (opcode == OP_JNZ);
  assign mov_memory = (opcode[5:3] == REG_MEM) || (opcode[2:0] == REG_MEM);
  assign eq_zero    = (rega == '0);
  assign jump_taken = (opcode == OP_JMP) || ((opcode == OP_JZ) && eq_zero) ||
                      ((opcode == OP_JNZ) && !eq_zero);
  assign idx        = cycle_reg - 4'd2;

  always_comb begin
    cur_state = S_NEXT;
    if (cycle_reg == 4'd0) begin
      cur_state = S_FETCH_PC;
    end else if (cycle_reg == 4'd1) begin
      cur_state = S_FETCH_INST;
    end else if (is_alu) begin
      if (idx == 4'd0) cur_state = S_ALU_OP;
    end else if (is_mov) begin
      case (idx)
        4'd0:    cur_state = S_MOV_FETCH;
        4'd1:    cur_state = S_MOV_LOAD;
        4'd2:    cur_state = S_MOV_STORE;
        default: cur_state = S_NEXT;
      endcase
    end else if (is_ldi || is_jump_op) begin
      case (idx)
        4'd0:    cur_state = S_FETCH_PC;
        4'd1:    cur_state = is_ldi ? S_LDI : S_JUMP;
        default: cur_state = S_NEXT;
      endcase
    end else if (opcode == OP_OUT) begin
      if (idx == 4'd0) cur_state = S_OUT_A;
    end else if (opcode == OP_HLT) begin
      if (idx == 4'd0) cur_state = S_HALT;
    end else if (opcode == OP_CALL) begin
      case (idx)
        4'd0:    cur_state = S_FETCH_PC;
        4'd1:    cur_state = S_TMP_STORE;
        4'd2:    cur_state = S_FETCH_SP;
        4'd3:    cur_state = S_PC_STORE;
        4'd4:    cur_state = S_TMP_JUMP;
        default: cur_state = S_NEXT;
      endcase
    end else if (opcode == OP_RET) begin
      case (idx)
        4'd0:    cur_state = S_INC_SP;
        4'd1:    cur_state = S_FETCH_SP;
        4'd2:    cur_state = S_RET;
        default: cur_state = S_NEXT;
      endcase
    end
  end

  // HALT holds the cycle count so the state stays HALT until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_reg  <= 4'd0;
      halted_reg <= 1'b0;
    end else begin
      if (cur_state == S_NEXT) begin
        cycle_reg <= 4'd0;
      end else if (cur_state != S_HALT) begin
        cycle_reg <= cycle_reg + 4'd1;
      end
      if (cur_state == S_HALT) halted_reg <= 1'b1;
    end
  end

  logic pc_en, pc_load, sp_en, sp_load, sp_down;

  assign pc_en = !halted_reg && (
                   (cur_state == S_FETCH_INST) || (cur_state == S_LDI) ||
                   (cur_state == S_TMP_STORE) ||
                   ((cur_state == S_JUMP) && !jump_taken) ||
                   ((cur_state == S_MOV_LOAD) && mov_memory));
  assign pc_load = reset || (!halted_reg && (
                   ((cur_state == S_JUMP) && jump_taken) ||
                   (cur_state == S_RET) || (cur_state == S_TMP_JUMP)));
  assign sp_en   = !halted_reg && ((cur_state == S_INC_SP) || (cur_state == S_TMP_JUMP));
  assign sp_down = (cur_state == S_TMP_JUMP);
  assign sp_load = reset;

  counter #(.WIDTH(WIDTH)) u_pc (
    .clk  (clk),
    .en   (pc_en),
    .load (pc_load),
    .down (1'b0),
    .d    (reset ? '0 : data_in),
    .q    (pc)
  );

  counter #(.WIDTH(WIDTH)) u_sp (
    .clk  (clk),
    .en   (sp_en),
    .load (sp_load),
    .down (sp_down),
    .d    ('1),
    .q    (sp)
  );

  always_comb begin
    alu_out = '0;
    case (alu_mode_t'(opcode[5:3]))
      ALU_ADD: alu_out = rega + regb;
      ALU_SUB: alu_out = rega - regb;
      ALU_INC: alu_out = rega + 1'b1;
      ALU_DEC: alu_out = rega - 1'b1;
      ALU_AND: alu_out = rega & regb;
      ALU_OR:  alu_out = rega | regb;
      ALU_XOR: alu_out = rega ^ regb;
      ALU_NOT: alu_out = ~rega;
      default: alu_out = '0;
    endcase
  end

  assign state  = cur_state;
  assign cycle  = cycle_reg;
  assign halted = halted_reg;

endmodule

// File: tb/tb_cpu_exec_core.sv
// Randomized instruction-level bench for cpu_exec_core with a reference model
// that predicts each instruction's state sequence and its net PC/SP effect.
module tb_cpu_exec_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] opcode = 8'h00, data_in = 8'h00, rega = 8'h00, regb = 8'h00;
  logic [7:0] state, pc, sp, alu_out;
  logic [3:0] cycle;
  logic       eq_zero, halted;

  int checks = 0;
  int passes = 0;
  logic [7:0] m_pc, m_sp;
  logic [7:0] seq[$];

  cpu_exec_core #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .data_in(data_in),
    .rega(rega), .regb(regb), .state(state), .cycle(cycle), .pc(pc),
    .sp(sp), .alu_out(alu_out), .eq_zero(eq_zero), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] ref_alu(input logic [7:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int r;
    case (op[5:3])
      3'd0: r = a + b;
      3'd1: r = a - b + 256;
      3'd2: r = a + 1;
      3'd3: r = a + 255;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = 255 - a;
    endcase
    return 8'(r % 256);
  endfunction

  // Expected micro-state list for one instruction, from cycle 0 to its NEXT/HALT.
  task automatic build_seq(input logic [7:0] op);
    seq = {8'h01, 8'h02};
    if (op[7:6] == 2'b01)                       seq = {seq, 8'h06, 8'h00};
    else if (op[7:6] == 2'b10)                  seq = {seq, 8'h07, 8'h08, 8'h09, 8'h00};
    else if (op[7:3] == 5'b00011)               seq = {seq, 8'h01, 8'h0A, 8'h00};
    else if (op >= 8'h10 && op <= 8'h12)        seq = {seq, 8'h01, 8'h04, 8'h00};
    else if (op == 8'h03)                       seq = {seq, 8'h05, 8'h00};
    else if (op == 8'h04)                       seq = {seq, 8'h03};
    else if (op == 8'h01)  seq = {seq, 8'h01, 8'h0D, 8'h0B, 8'h0C, 8'h0E, 8'h00};
    else if (op == 8'h02)  seq = {seq, 8'h0F, 8'h0B, 8'h10, 8'h00};
    else                   seq = {seq, 8'h00};
  endtask

  task automatic run_instr(input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] d);
    logic [7:0] pc0, sp0;
    opcode = op; rega = a; regb = b; data_in = d;
    #1;
    pc0 = m_pc; sp0 = m_sp;
    check("pc_start", pc, m_pc);
    check("sp_start", sp, m_sp);
    build_seq(op);
    for (int i = 0; i < seq.size(); i++) begin
      check("state", state, seq[i]);
      check("cycle", cycle, i);
      check("alu_out", alu_out, ref_alu(op, a, b));
      check("eq_zero", eq_zero, a == 0);
      check("halted_low", halted, 0);
      if (i == 2) check("pc_after_fetch", pc, 8'(pc0 + 1));
      tick();
    end
    // Net architectural effect of the whole instruction.
    m_pc = 8'(pc0 + 1);
    if (op[7:6] == 2'b10 && (op[5:3] == 3'b111 || op[2:0] == 3'b111)) m_pc = 8'(pc0 + 2);
    else if (op[7:3] == 5'b00011) m_pc = 8'(pc0 + 2);
    else if (op == 8'h10) m_pc = d;
    else if (op == 8'h11) m_pc = (a == 0) ? d : 8'(pc0 + 2);
    else if (op == 8'h12) m_pc = (a != 0) ? d : 8'(pc0 + 2);
    else if (op == 8'h01) begin m_pc = d; m_sp = 8'(sp0 - 1); end
    else if (op == 8'h02) begin m_pc = d; m_sp = 8'(sp0 + 1); end
    $display("instr op=%02h a=%02h b=%02h d=%02h -> pc=%02h sp=%02h (model pc=%02h sp=%02h)",
             op, a, b, d, pc, sp, m_pc, m_sp);
  endtask

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 9))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h02;
      3: return 8'h03;
      4: return 8'(8'h10 + $urandom_range(0, 2));
      5: return 8'(8'h18 | $urandom_range(0, 7));
      6: return 8'(8'h40 | $urandom_range(0, 63));
      7: return 8'(8'h80 | $urandom_range(0, 63));
      8: return 8'(8'hC0 | $urandom_range(0, 63));
      default: return 8'(8'h20 | $urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    logic [7:0] a;
    tick(); tick();
    check("rst_cycle", cycle, 0);
    check("rst_state", state, 8'h01);
    check("rst_pc", pc, 8'h00);
    check("rst_sp", sp, 8'hFF);
    check("rst_halted", halted, 0);
    reset = 1'b0;
    m_pc = 8'h00; m_sp = 8'hFF;

    opcode = 8'h40; rega = 8'hFF; regb = 8'h01; #1;
    check("alu_add_wrap", alu_out, 8'h00);
    check("eq_zero_ff", eq_zero, 0);
    opcode = 8'h48; rega = 8'h00; #1;
    check("alu_sub_wrap", alu_out, 8'hFF);
    check("eq_zero_00", eq_zero, 1);
    opcode = 8'h78; rega = 8'h0F; #1;
    check("alu_not", alu_out, 8'hF0);

    run_instr(8'h00, 8'h01, 8'h02, 8'h33);
    run_instr(8'h11, 8'h00, 8'h00, 8'h40);
    run_instr(8'h11, 8'h05, 8'h00, 8'h40);
    run_instr(8'h01, 8'h00, 8'h00, 8'h20);
    run_instr(8'h02, 8'h00, 8'h00, 8'h44);

    // Reset in the middle of CALL (cycle 4, FETCH_SP).
    opcode = 8'h01; data_in = 8'h77; #1;
    for (int i = 0; i < 4; i++) tick();
    check("midcall_cycle", cycle, 4);
    check("midcall_state", state, 8'h0B);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_cycle", cycle, 0);
    check("midrst_state", state, 8'h01);
    check("midrst_pc", pc, 8'h00);
    check("midrst_sp", sp, 8'hFF);
    check("midrst_halted", halted, 0);
    m_pc = 8'h00; m_sp = 8'hFF;

    for (int n = 0; n < 250; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run_instr(rand_op(), a, 8'($urandom), 8'($urandom));
    end

    // HLT: state and counters must freeze until reset.
    opcode = 8'h04; rega = 8'h00; data_in = 8'h55; #1;
    check("hlt_pc_start", pc, m_pc);
    tick(); tick();
    check("hlt_state_enter", state, 8'h03);
    check("hlt_halted_enter", halted, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hlt_state", state, 8'h03);
      check("hlt_cycle", cycle, 2);
      check("hlt_halted", halted, 1);
      check("hlt_pc", pc, 8'(m_pc + 1));
      check("hlt_sp", sp, m_sp);
    end
    $display("instr op=04 halted=%0d pc=%02h sp=%02h", halted, pc, sp);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("hlt_rst_halted", halted, 0);
    check("hlt_rst_state", state, 8'h01);
    check("hlt_rst_pc", pc, 8'h00);
    check("hlt_rst_sp", sp, 8'hFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
